// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the elastic pipeline stage
//
// Purpose: state encoding and small helpers used by pipe_stage_elastic.
// Ports:   none (package).
package pipe_pkg;

  // Encoding keeps bit 0 equal to "main entry valid" and bit 1 equal to
  // "skid entry valid", so the state can be read directly as occupancy flags.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    MAIN  = 2'b01,
    FULL  = 2'b11
  } pipe_state_t;

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - payload register with valid bit, load/unload/clear
//
// Purpose: one held pipeline entry; instanced for the main and skid slots.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      kill the entry (flush); payload zeroed when RESET_DATA != 0
//   load       capture d and mark valid
//   unload     mark invalid, payload kept
//   d, q       payload in/out, DATA_W bits
//   valid      entry holds data
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RESET_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  // rst/clear win over load so a killed entry can never be refilled by an
  // input accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      if (RESET_DATA != 0) begin
        q <= '0;
      end
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline stage register
//
// Purpose: one stage register between two pipeline stages, with an optional
// 2-entry skid buffer (registered in_ready) and a synchronous flush.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 kill all held entries
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload
//   occupancy             held entries, 0..2
//   bubble                ~out_valid
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SKID       = 1,
  parameter int RESET_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic              bubble
);

  logic              main_valid;
  logic              main_load;
  logic              main_unload;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic              skid_valid;
  logic              accept;
  logic              consume;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid & out_ready;

  pipe_entry_reg #(
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .load   (main_load),
    .unload (main_unload),
    .d      (main_d),
    .q      (main_q),
    .valid  (main_valid)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_t       state;
      pipe_state_t       state_nxt;
      logic              ready_q;
      logic              skid_load;
      logic              skid_unload;
      logic              skid_v;
      logic [DATA_W-1:0] skid_q;

      pipe_entry_reg #(
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
      ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (skid_load),
        .unload (skid_unload),
        .d      (in_data),
        .q      (skid_q),
        .valid  (skid_v)
      );

      always_comb begin
        state_nxt   = state;
        main_load   = 1'b0;
        main_unload = 1'b0;
        main_d      = in_data;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        case (state)
          EMPTY: begin
            if (accept) begin
              main_load = 1'b1;
              state_nxt = MAIN;
            end
          end
          MAIN: begin
            case ({accept, consume})
              2'b10: begin
                skid_load = 1'b1;
                state_nxt = FULL;
              end
              2'b01: begin
                main_unload = 1'b1;
                state_nxt   = EMPTY;
              end
              2'b11: begin
                main_load = 1'b1;
                state_nxt = MAIN;
              end
              default: state_nxt = MAIN;
            endcase
          end
          FULL: begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (consume) begin
              main_load   = 1'b1;
              main_d      = skid_q;
              skid_unload = 1'b1;
              state_nxt   = MAIN;
            end
          end
          default: state_nxt = EMPTY;
        endcase
      end

      // in_ready is computed from the next state so it is a pure flop output,
      // breaking any combinational path from out_ready to in_ready.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end else begin
          state   <= state_nxt;
          ready_q <= (state_nxt != FULL);
        end
      end

      assign in_ready   = ready_q;
      assign skid_valid = skid_v;
    end else begin : g_single
      assign main_load   = accept;
      assign main_unload = consume & ~accept;
      assign main_d      = in_data;
      // Combinational: the single slot can be refilled in the cycle it drains.
      assign in_ready    = ~main_valid | out_ready;
      assign skid_valid  = 1'b0;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = occ_count(main_valid, skid_valid);
  assign bubble    = ~main_valid;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SKID=1, DATA_W=32, RESET_DATA=0
  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_bubble;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  // Instance B: SKID=0, DATA_W=8, RESET_DATA=1
  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_bubble;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occ;

  pipe_stage_elastic #(.DATA_W(32), .SKID(1), .RESET_DATA(0)) u_a (
    .clk       (clk),
    .rst       (a_rst),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .occupancy (a_occ),
    .bubble    (a_bubble)
  );

  pipe_stage_elastic #(.DATA_W(8), .SKID(0), .RESET_DATA(1)) u_b (
    .clk       (clk),
    .rst       (b_rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occ),
    .bubble    (b_bubble)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic        ck;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] id,
                     input logic ordy, input logic e_ov, input logic [31:0] e_od,
                     input logic e_ir, input logic [1:0] e_occ, input logic ck);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ; v.ck = ck;
    vq.push_back(v);
  endtask

  initial begin
    int sent;
    int got;
    logic ir0;

    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Each row: inputs driven for one cycle, then outputs expected after the edge.
    // reset with input offered
    add(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 2'd0, 1'b0);
    // streaming 1..4
    add(1'b0, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1, 32'd1, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'd2, 1'b1, 1'b1, 32'd2, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'd3, 1'b1, 1'b1, 32'd3, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 32'd4, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 2'd0, 1'b0);
    // backpressure A/B, third input refused while full
    add(1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0);
    // flush while FULL with input offered
    add(1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 32'h44, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 32'h44, 1'b0, 2'd2, 1'b1);
    add(1'b0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0);
    // flush in MAIN overrides a real accept and coincides with a consume
    add(1'b0, 1'b0, 1'b1, 32'h66, 1'b0, 1'b1, 32'h66, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0);
    // reset mid-stream while FULL leaves nothing behind
    add(1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b1, 32'h77, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h88, 1'b0, 1'b1, 32'h77, 1'b0, 2'd2, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0);

    @(negedge clk);
    foreach (vq[i]) begin
      a_rst = vq[i].rst; a_flush = vq[i].flush; a_in_valid = vq[i].iv;
      a_in_data = vq[i].id; a_out_ready = vq[i].ordy;
      @(posedge clk);
      #1;
      chk("a_out_valid", i, {31'b0, a_out_valid}, {31'b0, vq[i].e_ov});
      chk("a_bubble",    i, {31'b0, a_bubble},    {31'b0, ~vq[i].e_ov});
      chk("a_in_ready",  i, {31'b0, a_in_ready},  {31'b0, vq[i].e_ir});
      chk("a_occupancy", i, {30'b0, a_occ},       {30'b0, vq[i].e_occ});
      if (vq[i].ck) chk("a_out_data", i, a_out_data, vq[i].e_od);
    end

    // Toggle: out_ready alternates while 0..15 is offered continuously.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      a_in_valid  = (sent < 16);
      a_in_data   = sent;
      a_out_ready = cyc[0];
      @(negedge clk);
      ir0 = a_in_ready;
      a_out_ready = ~a_out_ready;
      #1;
      chk("a_ready_indep", cyc, {31'b0, a_in_ready}, {31'b0, ir0});
      a_out_ready = ~a_out_ready;
      #1;
      if (a_in_valid && a_in_ready) sent++;
      if (a_out_valid && a_out_ready) begin
        chk("a_toggle_data", got, a_out_data, got);
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("a_toggle_count", 0, got, 32'd16);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("a_toggle_drained", 0, {31'b0, a_out_valid}, 32'd0);

    // Instance B: single entry, combinational in_ready.
    b_in_valid = 1'b1; b_in_data = 8'hEE;
    @(posedge clk); @(posedge clk); #1;
    chk("b_rst_valid", 0, {31'b0, b_out_valid}, 32'd0);
    chk("b_rst_data",  0, {24'b0, b_out_data},  32'd0);
    chk("b_rst_ready", 0, {31'b0, b_in_ready},  32'd1);
    chk("b_rst_occ",   0, {30'b0, b_occ},       32'd0);
    b_rst = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h5A; b_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("b_load_valid", 0, {31'b0, b_out_valid}, 32'd1);
    chk("b_load_data",  0, {24'b0, b_out_data},  32'h5A);
    chk("b_load_occ",   0, {30'b0, b_occ},       32'd1);
    b_in_data = 8'hA5;
    #1;
    chk("b_stall_ready", 0, {31'b0, b_in_ready}, 32'd0);
    b_out_ready = 1'b1;
    #1;
    chk("b_comb_ready", 0, {31'b0, b_in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("b_xfer_valid", 0, {31'b0, b_out_valid}, 32'd1);
    chk("b_xfer_data",  0, {24'b0, b_out_data},  32'hA5);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_drain_valid", 0, {31'b0, b_out_valid}, 32'd0);
    chk("b_drain_bubble", 0, {31'b0, b_bubble},   32'd1);
    b_in_valid = 1'b1; b_in_data = 8'h3C; b_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("b_pre_flush", 0, {24'b0, b_out_data}, 32'h3C);
    b_flush = 1'b1; b_in_data = 8'hC3;
    @(posedge clk); #1;
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk("b_flush_valid", 0, {31'b0, b_out_valid}, 32'd0);
    chk("b_flush_data",  0, {24'b0, b_out_data},  32'd0);
    chk("b_flush_ready", 0, {31'b0, b_in_ready},  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
